// File: rtl/spi_burst_protocol_pkg.sv
// spi_burst_protocol_pkg: state encodings, default widths and command field offsets
package spi_burst_protocol_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 8;
   localparam int LEN_W_DEF = 4;
   typedef enum logic [2:0] {IDLE, WR_WAIT, WR_BUS, RD_REQ, RD_WAIT, DONE} state_t;
   function automatic int rnw_bit(input int aw);
      return aw;
   endfunction
   function automatic int len_lsb(input int aw);
      return aw + 1;
   endfunction
   function automatic int len_msb(input int aw, input int lw);
      return aw + lw;
   endfunction
endpackage

// File: rtl/spi_burst_protocol_addr_gen.sv
// spi_burst_addr_gen: burst address/count tracker; SPI_BURST_AUTOINC_EN enables per-word address increment
module spi_burst_addr_gen #(
   parameter int ADDR_W = 8,
   parameter int LEN_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   output logic [ADDR_W-1:0] address,
   output logic              last
);
   logic [LEN_W-1:0] count;
   assign last = count == '0;
   // load on command, step once per completed burst word; address wraps naturally
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         address <= '0;
         count <= '0;
      end else if (load) begin
         address <= load_addr;
         count <= load_len;
      end else if (step) begin
         count <= count - 1'b1;
`ifdef SPI_BURST_AUTOINC_EN
         address <= address + 1'b1;
`else
         address <= address;
`endif
      end
endmodule

// File: rtl/spi_burst_protocol.sv
// spi_burst_protocol: SPI command/burst engine to register bus (SPI_BURST_AUTOINC_EN: auto-increment address)
module spi_burst_protocol
   import spi_burst_protocol_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_fe_in,
   input  logic              word_strb,
   input  logic              frame_end,
   input  logic [DATA_W-1:0] data_in,
   input  logic              ready,
   output logic [DATA_W-1:0] data_fe_out,
   output logic [DATA_W-1:0] data_out,
   output logic [ADDR_W-1:0] address,
   output logic              we,
   output logic              re,
   output logic              busy,
   output logic              overrun
);
   localparam int RNW = rnw_bit(ADDR_W);
   localparam int LLSB = len_lsb(ADDR_W);
   localparam int LMSB = len_msb(ADDR_W, LEN_W);
   state_t state;
   logic abort, last, load, step;
   assign busy = state != IDLE;
   assign load = state == IDLE && word_strb && !frame_end;
   assign step = !frame_end && !last &&
                 ((state == WR_BUS && ready && !abort) || (state == RD_WAIT && word_strb));
   spi_burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
      .clk(clk),
      .rst(rst),
      .load(load),
      .step(step),
      .load_addr(data_fe_in[ADDR_W-1:0]),
      .load_len(data_fe_in[LMSB:LLSB]),
      .address(address),
      .last(last)
   );
   // transaction FSM: frame_end dominates word_strb; pending bus requests finish before abort takes effect
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         abort <= 1'b0;
         data_fe_out <= '0;
         data_out <= '0;
         we <= 1'b0;
         re <= 1'b0;
         overrun <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (frame_end) data_fe_out <= '0;
               else if (word_strb) begin
                  overrun <= 1'b0;
                  abort <= 1'b0;
                  re <= data_fe_in[RNW];
                  state <= data_fe_in[RNW] ? RD_REQ : WR_WAIT;
               end
            WR_WAIT:
               if (frame_end) begin
                  data_fe_out <= '0;
                  state <= IDLE;
               end else if (word_strb) begin
                  data_out <= data_fe_in;
                  we <= 1'b1;
                  state <= WR_BUS;
               end
            WR_BUS: begin
               if (word_strb && !frame_end) overrun <= 1'b1;
               if (ready) begin
                  we <= 1'b0;
                  data_fe_out <= '0;
                  state <= (abort || frame_end) ? IDLE : last ? DONE : WR_WAIT;
               end else if (frame_end) abort <= 1'b1;
            end
            RD_REQ: begin
               if (word_strb && !frame_end) overrun <= 1'b1;
               if (ready) begin
                  re <= 1'b0;
                  data_fe_out <= (abort || frame_end) ? '0 : data_in;
                  state <= (abort || frame_end) ? IDLE : RD_WAIT;
               end else if (frame_end) abort <= 1'b1;
            end
            RD_WAIT:
               if (frame_end) begin
                  data_fe_out <= '0;
                  state <= IDLE;
               end else if (word_strb) begin
                  if (last) data_fe_out <= '0;
                  re <= !last;
                  state <= last ? DONE : RD_REQ;
               end
            DONE: begin
               data_fe_out <= '0;
               if (frame_end) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_spi_burst_protocol.sv
// tb_spi_burst_protocol: directed-vector self-checking bench for spi_burst_protocol
module tb_spi_burst_protocol;
`ifdef SPI_BURST_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [31:0] data_fe_in = '0;
   logic word_strb = 1'b0;
   logic frame_end = 1'b0;
   logic [31:0] data_in;
   logic ready = 1'b0;
   logic [31:0] data_fe_out, data_out;
   logic [7:0] address;
   logic we, re, busy, overrun;
   int checks = 0;
   int failures = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   logic [31:0] last_wr_data = '0;
   logic [7:0] last_wr_addr = '0;

   spi_burst_protocol dut (
      .clk(clk),
      .rst(rst),
      .data_fe_in(data_fe_in),
      .word_strb(word_strb),
      .frame_end(frame_end),
      .data_in(data_in),
      .ready(ready),
      .data_fe_out(data_fe_out),
      .data_out(data_out),
      .address(address),
      .we(we),
      .re(re),
      .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;
   assign data_in = 32'(address) + 32'h100;

   always @(posedge clk) begin
      if (rst && we && ready) begin
         wr_cnt <= wr_cnt + 1;
         last_wr_data <= data_out;
         last_wr_addr <= address;
      end
      if (rst && re && ready) rd_cnt <= rd_cnt + 1;
   end

   function automatic logic [31:0] cmd(input logic [7:0] a, input logic rnw, input logic [3:0] len);
      return {19'b0, len, rnw, a};
   endfunction

   task automatic strobe(input logic [31:0] d);
      data_fe_in = d;
      word_strb = 1'b1;
      @(negedge clk);
      word_strb = 1'b0;
   endtask

   task automatic fend();
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({data_fe_out, data_out, address, we, re, busy, overrun} !== 76'd0) begin
         failures++;
         $display("FAIL reset_outputs: got dfo=%h do=%h a=%h we=%b re=%b busy=%b ovr=%b, expected all 0", data_fe_out, data_out, address, we, re, busy, overrun);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_write();
      int w0;
      w0 = wr_cnt;
      ready = 1'b1;
      strobe(cmd(8'h10, 1'b0, 4'd0));
      checks++;
      if (busy !== 1'b1 || we !== 1'b0) begin
         failures++;
         $display("FAIL sw_cmd: got busy=%b we=%b expected busy=1 we=0", busy, we);
      end
      strobe(32'hDEADBEEF);
      checks++;
      if (we !== 1'b1 || address !== 8'h10 || data_out !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL sw_we: got we=%b a=%h do=%h expected we=1 a=10 do=deadbeef", we, address, data_out);
      end
      @(negedge clk);
      checks++;
      if (we !== 1'b0 || busy !== 1'b1 || wr_cnt - w0 !== 1) begin
         failures++;
         $display("FAIL sw_done: got we=%b busy=%b writes=%0d expected we=0 busy=1 writes=1", we, busy, wr_cnt - w0);
      end
      fend();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL sw_idle: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_burst_read();
      logic [7:0] e;
      ready = 1'b1;
      strobe(cmd(8'h20, 1'b1, 4'd3));
      checks++;
      if (re !== 1'b1 || address !== 8'h20) begin
         failures++;
         $display("FAIL br_req0: got re=%b a=%h expected re=1 a=20", re, address);
      end
      @(negedge clk);
      checks++;
      if (data_fe_out !== 32'h120 || re !== 1'b0) begin
         failures++;
         $display("FAIL br_data0: got dfo=%h re=%b expected dfo=120 re=0", data_fe_out, re);
      end
      for (int i = 1; i < 4; i++) begin
         e = AUTOINC ? 8'h20 + 8'(i) : 8'h20;
         strobe(32'h0);
         checks++;
         if (re !== 1'b1 || address !== e) begin
            failures++;
            $display("FAIL br_req%0d: got re=%b a=%h expected re=1 a=%h", i, re, address, e);
         end
         @(negedge clk);
         checks++;
         if (data_fe_out !== 32'h100 + 32'(e)) begin
            failures++;
            $display("FAIL br_data%0d: got %h expected %h", i, data_fe_out, 32'h100 + 32'(e));
         end
      end
      strobe(32'h0);
      checks++;
      if (data_fe_out !== 32'h0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL br_done: got dfo=%h busy=%b expected dfo=0 busy=1", data_fe_out, busy);
      end
      fend();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL br_idle: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_wrap_backpressure();
      logic [7:0] e;
      logic [31:0] d;
      ready = 1'b0;
      strobe(cmd(8'hFE, 1'b0, 4'd2));
      for (int i = 0; i < 3; i++) begin
         e = AUTOINC ? 8'hFE + 8'(i) : 8'hFE;
         d = 32'hA000 + 32'(i);
         strobe(d);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (we !== 1'b1 || address !== e) begin
               failures++;
               $display("FAIL wb_hold%0d_%0d: got we=%b a=%h expected we=1 a=%h", i, k, we, address, e);
            end
            @(negedge clk);
         end
         ready = 1'b1;
         @(negedge clk);
         ready = 1'b0;
         checks++;
         if (we !== 1'b0 || last_wr_addr !== e || last_wr_data !== d) begin
            failures++;
            $display("FAIL wb_xfer%0d: got we=%b a=%h d=%h expected we=0 a=%h d=%h", i, we, last_wr_addr, last_wr_data, e, d);
         end
      end
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL wb_done: got busy=%b expected 1", busy);
      end
      fend();
   endtask

   task automatic test_overrun();
      int w0;
      ready = 1'b0;
      strobe(cmd(8'h30, 1'b0, 4'd1));
      strobe(32'h1111);
      w0 = wr_cnt;
      strobe(32'h2222);
      checks++;
      if (overrun !== 1'b1 || data_out !== 32'h1111 || we !== 1'b1) begin
         failures++;
         $display("FAIL ov_set: got ovr=%b do=%h we=%b expected ovr=1 do=1111 we=1", overrun, data_out, we);
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      checks++;
      if (wr_cnt - w0 !== 1 || last_wr_data !== 32'h1111) begin
         failures++;
         $display("FAIL ov_written: got writes=%0d d=%h expected writes=1 d=1111", wr_cnt - w0, last_wr_data);
      end
      fend();
      checks++;
      if (overrun !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL ov_sticky: got ovr=%b busy=%b expected ovr=1 busy=0", overrun, busy);
      end
      strobe(cmd(8'h40, 1'b0, 4'd0));
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL ov_clear: got %b expected 0", overrun);
      end
      ready = 1'b1;
      strobe(32'h3333);
      @(negedge clk);
      fend();
   endtask

   task automatic test_abort();
      int r0;
      r0 = rd_cnt;
      ready = 1'b0;
      strobe(cmd(8'h50, 1'b1, 4'd1));
      fend();
      checks++;
      if (re !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL ab_hold: got re=%b busy=%b expected re=1 busy=1", re, busy);
      end
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      checks++;
      if (re !== 1'b0 || busy !== 1'b0 || data_fe_out !== 32'h0 || rd_cnt - r0 !== 1) begin
         failures++;
         $display("FAIL ab_idle: got re=%b busy=%b dfo=%h reads=%0d expected re=0 busy=0 dfo=0 reads=1", re, busy, data_fe_out, rd_cnt - r0);
      end
   endtask

   task automatic test_same_cycle();
      int w0;
      w0 = wr_cnt;
      ready = 1'b1;
      strobe(cmd(8'h80, 1'b0, 4'd0));
      data_fe_in = 32'h5555;
      word_strb = 1'b1;
      frame_end = 1'b1;
      @(negedge clk);
      word_strb = 1'b0;
      frame_end = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || we !== 1'b0 || overrun !== 1'b0 || wr_cnt !== w0) begin
         failures++;
         $display("FAIL sc_frame_wins: got busy=%b we=%b ovr=%b writes=%0d expected 0 0 0 0", busy, we, overrun, wr_cnt - w0);
      end
   endtask

   task automatic test_reset_mid();
      ready = 1'b0;
      strobe(cmd(8'h60, 1'b0, 4'd3));
      strobe(32'hAAAA);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({data_fe_out, data_out, address, we, re, busy, overrun} !== 76'd0) begin
         failures++;
         $display("FAIL rm_async: got dfo=%h do=%h a=%h we=%b re=%b busy=%b ovr=%b expected all 0", data_fe_out, data_out, address, we, re, busy, overrun);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      ready = 1'b1;
      strobe(cmd(8'h70, 1'b0, 4'd0));
      strobe(32'hBBBB);
      checks++;
      if (we !== 1'b1 || address !== 8'h70 || data_out !== 32'hBBBB) begin
         failures++;
         $display("FAIL rm_next: got we=%b a=%h do=%h expected we=1 a=70 do=bbbb", we, address, data_out);
      end
      @(negedge clk);
      fend();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst_read();
      test_wrap_backpressure();
      test_overrun();
      test_abort();
      test_same_cycle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
